// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two CPU requester ports (imem/dmem), mem_arbiter and the shared slave port.
// The slave modport is the arbiter's view; the master modport is the requester/slave environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  imem_valid;
  logic                  imem_instr;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic [STRB_WIDTH-1:0] imem_wstrb;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  imem_ready;

  logic                  dmem_valid;
  logic                  dmem_instr;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [STRB_WIDTH-1:0] dmem_wstrb;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ready;

  logic                  mem_valid;
  logic                  mem_instr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  imem_valid, imem_instr, imem_addr, imem_wdata, imem_wstrb,
    output imem_rdata, imem_ready,
    input  dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ready,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport master (
    output imem_valid, imem_instr, imem_addr, imem_wdata, imem_wstrb,
    input  imem_rdata, imem_ready,
    output dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ready,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one slow memory slave between the CPU imem and dmem ports: one outstanding transaction,
// losing requests buffered, completions routed only to the owning requester.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic                  instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } req_t;

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic       pend_i_q, pend_i_d;
  logic       pend_d_q, pend_d_d;
  req_t       pbuf_i_q, pbuf_i_d;
  req_t       pbuf_d_q, pbuf_d_d;
  logic       mem_valid_q, mem_valid_d;
  req_t       mem_req_q, mem_req_d;

  req_t live_i_s, live_d_s, sel_i_s, sel_d_s;
  logic owns_i_s, owns_d_s, new_i_s, new_d_s, cand_i_s, cand_d_s;
  logic grant_ok_s, grant_s, win_d_s, cpl_s;

  assign live_i_s = {bus.imem_instr, bus.imem_addr, bus.imem_wdata, bus.imem_wstrb};
  assign live_d_s = {bus.dmem_instr, bus.dmem_addr, bus.dmem_wdata, bus.dmem_wstrb};
  assign sel_i_s  = pend_i_q ? pbuf_i_q : live_i_s;
  assign sel_d_s  = pend_d_q ? pbuf_d_q : live_d_s;

  // A requester that still owns the slave (not completing this cycle) or already has a buffered
  // request may not inject another one; such a pulse is dropped.
  assign owns_i_s   = (state_q == BUSY) && (owner_q == PORT_I) && !bus.mem_ready;
  assign owns_d_s   = (state_q == BUSY) && (owner_q == PORT_D) && !bus.mem_ready;
  assign new_i_s    = bus.imem_valid && !pend_i_q && !owns_i_s;
  assign new_d_s    = bus.dmem_valid && !pend_d_q && !owns_d_s;
  assign cand_i_s   = pend_i_q || new_i_s;
  assign cand_d_s   = pend_d_q || new_d_s;
  assign grant_ok_s = (state_q == IDLE) || bus.mem_ready;
  assign grant_s    = grant_ok_s && (cand_i_s || cand_d_s);
  assign cpl_s      = (state_q == BUSY) && bus.mem_ready;

  // Winner selection: 1 means dmem wins
  always_comb begin
    if (cand_i_s && cand_d_s) begin
      if (ROUND_ROBIN) begin
        win_d_s = (last_grant_q == PORT_I);
      end else begin
        win_d_s = 1'b1;
      end
    end else begin
      win_d_s = cand_d_s;
    end
  end

  // Next-state: capture new requests, then issue the winner and release its buffer
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    pend_i_d     = pend_i_q;
    pend_d_d     = pend_d_q;
    pbuf_i_d     = pbuf_i_q;
    pbuf_d_d     = pbuf_d_q;
    mem_valid_d  = 1'b0;
    mem_req_d    = mem_req_q;
    if (new_i_s) begin
      pend_i_d = 1'b1;
      pbuf_i_d = live_i_s;
    end else begin
      pend_i_d = pend_i_q;
    end
    if (new_d_s) begin
      pend_d_d = 1'b1;
      pbuf_d_d = live_d_s;
    end else begin
      pend_d_d = pend_d_q;
    end
    if (grant_s) begin
      mem_valid_d  = 1'b1;
      state_d      = BUSY;
      owner_d      = win_d_s;
      last_grant_d = win_d_s;
      if (win_d_s) begin
        mem_req_d = sel_d_s;
        pend_d_d  = 1'b0;
      end else begin
        mem_req_d = sel_i_s;
        pend_i_d  = 1'b0;
      end
    end else if (grant_ok_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_I;
      pend_i_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      pbuf_i_q     <= '0;
      pbuf_d_q     <= '0;
      mem_valid_q  <= 1'b0;
      mem_req_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      pend_i_q     <= pend_i_d;
      pend_d_q     <= pend_d_d;
      pbuf_i_q     <= pbuf_i_d;
      pbuf_d_q     <= pbuf_d_d;
      mem_valid_q  <= mem_valid_d;
      mem_req_q    <= mem_req_d;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_instr = mem_req_q.instr;
  assign bus.mem_addr  = mem_req_q.addr;
  assign bus.mem_wdata = mem_req_q.wdata;
  assign bus.mem_wstrb = mem_req_q.wstrb;

  // Completion is passed through combinationally, only to the owner
  assign bus.imem_ready = cpl_s && (owner_q == PORT_I);
  assign bus.dmem_ready = cpl_s && (owner_q == PORT_D);
  assign bus.imem_rdata = (cpl_s && (owner_q == PORT_I)) ? bus.mem_rdata : '0;
  assign bus.dmem_rdata = (cpl_s && (owner_q == PORT_D)) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: unit 0 uses round-robin, unit 1 fixed dmem priority.
module tb_mem_arbiter;
  typedef struct packed {
    logic        port;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  logic        req_valid [2][2];
  logic        req_instr [2][2];
  logic [31:0] req_addr  [2][2];
  logic [31:0] req_wdata [2][2];
  logic [3:0]  req_wstrb [2][2];
  logic        s_ready   [2];
  logic [31:0] s_rdata   [2];

  exp_t exp_q [2][$];
  logic exp_busy  [2];
  logic exp_owner [2];
  int   mv_cnt    [2];
  int   rdy_cnt   [2][2];

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    assign bus.imem_valid = req_valid[g][0];
    assign bus.imem_instr = req_instr[g][0];
    assign bus.imem_addr  = req_addr[g][0];
    assign bus.imem_wdata = req_wdata[g][0];
    assign bus.imem_wstrb = req_wstrb[g][0];
    assign bus.dmem_valid = req_valid[g][1];
    assign bus.dmem_instr = req_instr[g][1];
    assign bus.dmem_addr  = req_addr[g][1];
    assign bus.dmem_wdata = req_wdata[g][1];
    assign bus.dmem_wstrb = req_wstrb[g][1];
    assign bus.mem_ready  = s_ready[g];
    assign bus.mem_rdata  = s_rdata[g];

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(g == 0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    // Scoreboard: pops expected requests on mem_valid, predicts completion routing each cycle
    initial begin : mon
      exp_t e;
      logic ir, dr;
      exp_busy[g]   = 1'b0;
      exp_owner[g]  = 1'b0;
      mv_cnt[g]     = 0;
      rdy_cnt[g][0] = 0;
      rdy_cnt[g][1] = 0;
      forever begin
        @(negedge clock);
        if (reset) begin
          exp_busy[g] = 1'b0;
        end else begin
          ir = exp_busy[g] && s_ready[g] && !exp_owner[g];
          dr = exp_busy[g] && s_ready[g] && exp_owner[g];
          chk($sformatf("u%0d imem_ready", g), 64'(bus.imem_ready), 64'(ir));
          chk($sformatf("u%0d dmem_ready", g), 64'(bus.dmem_ready), 64'(dr));
          chk($sformatf("u%0d imem_rdata", g), 64'(bus.imem_rdata), ir ? 64'(s_rdata[g]) : 64'd0);
          chk($sformatf("u%0d dmem_rdata", g), 64'(bus.dmem_rdata), dr ? 64'(s_rdata[g]) : 64'd0);
          if (bus.imem_ready) rdy_cnt[g][0]++;
          if (bus.dmem_ready) rdy_cnt[g][1]++;
          if (s_ready[g]) exp_busy[g] = 1'b0;
          if (bus.mem_valid) begin
            mv_cnt[g]++;
            if (exp_q[g].size() == 0) begin
              chk($sformatf("u%0d unexpected mem_valid", g), 64'(bus.mem_valid), 64'd0);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("u%0d mem_addr", g),  64'(bus.mem_addr),  64'(e.addr));
              chk($sformatf("u%0d mem_instr", g), 64'(bus.mem_instr), 64'(e.instr));
              chk($sformatf("u%0d mem_wdata", g), 64'(bus.mem_wdata), 64'(e.wdata));
              chk($sformatf("u%0d mem_wstrb", g), 64'(bus.mem_wstrb), 64'(e.wstrb));
              exp_busy[g]  = 1'b1;
              exp_owner[g] = e.port;
            end
          end
        end
      end
    end
  end

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      s_ready[k] = 1'b0;
      s_rdata[k] = 32'h0;
      for (int p = 0; p < 2; p++) begin
        req_valid[k][p] = 1'b0;
        req_instr[k][p] = 1'b0;
        req_addr[k][p]  = 32'h0;
        req_wdata[k][p] = 32'h0;
        req_wstrb[k][p] = 4'h0;
      end
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic req(input int k, input logic p, input logic instr, input logic [31:0] a,
                     input logic [31:0] w, input logic [3:0] s);
    req_valid[k][p] = 1'b1;
    req_instr[k][p] = instr;
    req_addr[k][p]  = a;
    req_wdata[k][p] = w;
    req_wstrb[k][p] = s;
  endtask

  task automatic push(input int k, input logic p, input logic instr, input logic [31:0] a,
                      input logic [31:0] w, input logic [3:0] s);
    exp_q[k].push_back(exp_t'{port: p, instr: instr, addr: a, wdata: w, wstrb: s});
  endtask

  task automatic rsp(input int k, input logic [31:0] d);
    s_ready[k] = 1'b1;
    s_rdata[k] = d;
  endtask

  initial begin
    int          m0;
    int          d0;
    logic [31:0] a_i;
    logic [31:0] a_d;
    clr();
    reset = 1'b1;
    nxt();
    nxt();
    mid();
    chk("rst mem_valid", 64'(gen[0].bus.mem_valid), 64'd0);
    chk("rst mem_addr",  64'(gen[0].bus.mem_addr),  64'd0);
    chk("rst mem_wdata", 64'(gen[0].bus.mem_wdata), 64'd0);
    chk("rst mem_wstrb", 64'(gen[0].bus.mem_wstrb), 64'd0);
    chk("rst mem_instr", 64'(gen[0].bus.mem_instr), 64'd0);
    chk("rst u1 mem_valid", 64'(gen[1].bus.mem_valid), 64'd0);
    nxt();
    reset = 1'b0;
    nxt();

    // Round-robin conflict right after reset: dmem wins, buffered imem follows back-to-back
    req(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    push(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    push(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    nxt();
    mid();
    chk("rr first addr", 64'(gen[0].bus.mem_addr), 64'h20);
    nxt();
    rsp(0, 32'h2222_0000);
    nxt();
    mid();
    chk("rr b2b valid", 64'(gen[0].bus.mem_valid), 64'd1);
    chk("rr b2b addr",  64'(gen[0].bus.mem_addr),  64'h10);
    nxt();
    rsp(0, 32'h1111_0000);
    nxt();
    // lone dmem access, then a second pair: imem must win this time
    req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    push(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    nxt();
    nxt();
    rsp(0, 32'h3030_3030);
    nxt();
    req(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
    req(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    push(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
    push(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    nxt();
    mid();
    chk("rr second pair addr", 64'(gen[0].bus.mem_addr), 64'h14);
    nxt();
    rsp(0, 32'h1414_1414);
    nxt();
    nxt();
    rsp(0, 32'h2424_2424);
    nxt();

    // Single read with slave latency of three cycles
    req(0, 1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    push(0, 1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    nxt();
    mid();
    chk("read valid T+1", 64'(gen[0].bus.mem_valid), 64'd1);
    chk("read addr",      64'(gen[0].bus.mem_addr),  64'h100);
    chk("read instr",     64'(gen[0].bus.mem_instr), 64'd1);
    nxt();
    mid();
    chk("read valid T+2", 64'(gen[0].bus.mem_valid), 64'd0);
    chk("read addr hold", 64'(gen[0].bus.mem_addr),  64'h100);
    nxt();
    rsp(0, 32'hDEAD_BEEF);
    mid();
    chk("read imem_ready", 64'(gen[0].bus.imem_ready), 64'd1);
    chk("read imem_rdata", 64'(gen[0].bus.imem_rdata), 64'hDEAD_BEEF);
    chk("read dmem_ready", 64'(gen[0].bus.dmem_ready), 64'd0);
    nxt();

    // imem request arriving while a dmem write is outstanding is held pending
    d0 = rdy_cnt[0][1];
    req(0, 1'b1, 1'b0, 32'h40, 32'h55AA_55AA, 4'hF);
    push(0, 1'b1, 1'b0, 32'h40, 32'h55AA_55AA, 4'hF);
    nxt();
    nxt();
    req(0, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0);
    push(0, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0);
    nxt();
    nxt();
    rsp(0, 32'h0);
    mid();
    chk("busy no early valid", 64'(gen[0].bus.mem_valid), 64'd0);
    nxt();
    mid();
    chk("busy pend valid", 64'(gen[0].bus.mem_valid), 64'd1);
    chk("busy pend addr",  64'(gen[0].bus.mem_addr),  64'h80);
    nxt();
    nxt();
    rsp(0, 32'h8080_8080);
    nxt();
    chk("busy dmem_ready once", 64'(rdy_cnt[0][1] - d0), 64'd1);

    // Spurious slave completion in IDLE
    rsp(0, 32'hBAD0_BAD0);
    mid();
    chk("idle imem_ready", 64'(gen[0].bus.imem_ready), 64'd0);
    chk("idle dmem_ready", 64'(gen[0].bus.dmem_ready), 64'd0);
    nxt();

    // Second dmem pulse while dmem owns the slave is dropped
    m0 = mv_cnt[0];
    d0 = rdy_cnt[0][1];
    req(0, 1'b1, 1'b0, 32'h60, 32'h6, 4'hF);
    push(0, 1'b1, 1'b0, 32'h60, 32'h6, 4'hF);
    nxt();
    nxt();
    req(0, 1'b1, 1'b0, 32'h64, 32'h7, 4'hF);
    nxt();
    rsp(0, 32'h6060_6060);
    nxt();
    nxt();
    nxt();
    chk("viol mem_valid count",  64'(mv_cnt[0] - m0),      64'd1);
    chk("viol dmem_ready count", 64'(rdy_cnt[0][1] - d0), 64'd1);

    // Reset while a transaction is outstanding
    req(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'h0);
    push(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'h0);
    nxt();
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    mid();
    chk("mid-rst mem_valid", 64'(gen[0].bus.mem_valid), 64'd0);
    chk("mid-rst mem_addr",  64'(gen[0].bus.mem_addr),  64'd0);
    chk("mid-rst mem_instr", 64'(gen[0].bus.mem_instr), 64'd0);
    nxt();
    rsp(0, 32'h5555_5555);
    mid();
    chk("mid-rst late ready", 64'(gen[0].bus.imem_ready), 64'd0);
    chk("mid-rst late rdata", 64'(gen[0].bus.imem_rdata), 64'd0);
    nxt();
    req(0, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    push(0, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    nxt();
    mid();
    chk("post-rst valid", 64'(gen[0].bus.mem_valid), 64'd1);
    chk("post-rst addr",  64'(gen[0].bus.mem_addr),  64'h300);
    nxt();
    rsp(0, 32'h3000_0003);
    nxt();

    // Fixed priority unit: dmem first in every pair, buffered imem before the next pair
    for (int i = 0; i < 3; i++) begin
      a_i = 32'hB0 + 32'(i * 16);
      a_d = 32'hA0 + 32'(i * 16);
      req(1, 1'b0, 1'b1, a_i, 32'h0, 4'h0);
      req(1, 1'b1, 1'b0, a_d, 32'hC0DE_0000 + 32'(i), 4'h3);
      push(1, 1'b1, 1'b0, a_d, 32'hC0DE_0000 + 32'(i), 4'h3);
      push(1, 1'b0, 1'b1, a_i, 32'h0, 4'h0);
      nxt();
      mid();
      chk("fp dmem first", 64'(gen[1].bus.mem_addr), 64'(a_d));
      nxt();
      rsp(1, 32'hD000_0000 + 32'(i));
      nxt();
      mid();
      chk("fp imem next", 64'(gen[1].bus.mem_addr), 64'(a_i));
      nxt();
      rsp(1, 32'hE000_0000 + 32'(i));
      nxt();
    end

    nxt();
    nxt();
    chk("u0 queue drained", 64'(exp_q[0].size()), 64'd0);
    chk("u1 queue drained", 64'(exp_q[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one memory slave port between the CPU instruction port (imem) and data port (dmem).
- Sits between the cpu and a single slow slave, e.g. the Avalon bridge, in the SoC interconnect.
- Buffers a losing request instead of dropping it, allows one outstanding transaction, and routes each completion only to the requester that owns it.
- Round-robin or fixed data-priority arbitration.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; the strobe width is DATA_WIDTH/8.
- ROUND_ROBIN, 1, 1 = alternate on conflict, 0 = dmem always wins.

Ports:
- reset  in  1  synchronous, active-high
- clock  in  1  single clock, rising edge
- imem_valid  in  1  one-cycle request pulse from instruction port
- imem_instr  in  1  instruction-fetch flag
- imem_addr  in  ADDR_WIDTH  request address
- imem_wdata  in  DATA_WIDTH  write data
- imem_wstrb  in  DATA_WIDTH/8  byte strobes; 0 = read
- imem_rdata  out  DATA_WIDTH  read data, valid with imem_ready
- imem_ready  out  1  one-cycle completion pulse
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb, dmem_rdata, dmem_ready: same as imem_* for the data port
- mem_valid  out  1  one-cycle request pulse to slave
- mem_instr  out  1  forwarded instr flag
- mem_addr  out  ADDR_WIDTH  forwarded address
- mem_wdata  out  DATA_WIDTH  forwarded write data
- mem_wstrb  out  DATA_WIDTH/8  forwarded strobes
- mem_rdata  in  DATA_WIDTH  slave read data
- mem_ready  in  1  slave completion pulse

Behaviour:
- Reset state:
  - All mem_* outputs are 0; imem_ready/dmem_ready are 0 and imem_rdata/dmem_rdata are 0.
  - FSM is IDLE, both pending buffers are empty, and last_grant = IMEM, so the first conflict goes to dmem.
- Candidates each cycle: cand_x = pend_x | x_valid. The fields come from the pending buffer when pend_x, else from the live inputs.
- FSM states:
  - IDLE: no outstanding transaction.
  - BUSY: one transaction outstanding, and the owner register holds IMEM or DMEM.
- Grant condition: a grant is evaluated in any cycle where state = IDLE, or state = BUSY with mem_ready = 1.
- Grant selection:
  - Only one candidate: it wins.
  - Both candidates with ROUND_ROBIN = 1: the winner is the requester other than last_grant.
  - Both candidates with ROUND_ROBIN = 0: dmem wins.
- Effects of a grant, at the clock edge:
  - The winner's fields load into the mem_* output registers, and mem_valid = 1 for exactly the next cycle.
  - State becomes BUSY, owner = winner, last_grant = winner, and the winner's pend flag clears.
- Losing live request: captured into its pending buffer at the same edge.
- No grant condition: any live x_valid is captured into pend_x.
- Latency:
  - Uncontended request at cycle T gives mem_valid at T+1.
  - Completion is combinational: in the mem_ready cycle, owner_ready = 1 and owner_rdata = mem_rdata.
  - The non-owner's ready and rdata stay 0.
- Back-to-back: a grant in the mem_ready cycle issues the next mem_valid on the following cycle, with no idle bubble.
- No grant candidate on mem_ready: state returns to IDLE.
- mem_valid: deasserted after one cycle. mem_addr/wdata/wstrb/instr hold their values until the next grant.
- mem_ready in IDLE: ignored; no requester ready is produced.
- Owner re-request: a requester may assert valid in the same cycle as its own ready; that request is a normal candidate.
- Protocol violation: a requester asserting valid while it is pending or owns the outstanding transaction has its new request dropped. The buffered or outstanding request is unaffected.
- Reset mid-transaction: all state clears, and the outstanding transaction is abandoned. A later mem_ready is ignored because the FSM is IDLE.
- Fields are forwarded unmodified; the arbiter performs no address translation.

Test Plan:
- Single read: imem_valid at T with addr 0x100, wstrb 0; slave returns mem_ready at T+3 with rdata 0xDEADBEEF -> mem_valid only at T+1 with mem_addr 0x100 and mem_instr = imem_instr; imem_ready = 1 with imem_rdata 0xDEADBEEF at T+3; dmem_ready stays 0.
- Conflict, ROUND_ROBIN = 1, after reset: imem 0x10 and dmem 0x20 both at T -> mem_addr 0x20 first; after its mem_ready, 0x10 issues the next cycle. A second simultaneous pair -> imem is granted first.
- ROUND_ROBIN = 0: three simultaneous imem/dmem pairs -> dmem is granted first every time; each buffered imem is served before the next pair's dmem.
- Busy capture: dmem write (0x40, wdata 0x55AA55AA, wstrb 0xF) is outstanding; imem_valid 0x80 arrives meanwhile -> 0x80 is held pending and mem_valid for 0x80 occurs in the cycle after the dmem mem_ready; dmem_ready pulses once.
- Spurious and violation: mem_ready in IDLE -> no ready output. Second dmem_valid while dmem is outstanding -> only one mem_valid and one dmem_ready.
- Reset mid-BUSY: assert reset while outstanding; mem_ready arrives after reset -> all outputs 0, no ready pulse; the next imem request issues normally.
